seg7_scan_rx: RTL and testbench

Receive side of the four-digit common-anode seven-segment scan interface. The block samples the multiplexed active-low digit-select and segment lines that a scan driver produces. It reconstructs the BCD value shown on each digit and publishes a coherent 4-digit frame once every digit has been seen. It is used for loopback checking of the display driver and for reading the display bus from another board.

---
 rtl/seg7_pkg.sv | 31 +++
 rtl/seg7_decode.sv | 31 +++
 rtl/seg7_scan_rx.sv | 158 +++++++++++++++
 tb/tb_seg7_scan_rx.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared seven-segment codes, digit count and frame states
package seg7_pkg;

  localparam int NUM_DIGITS = 4;
  localparam logic [3:0] BCD_INVALID = 4'hF;

  // Active-high gfedcba patterns, shared with the scan driver.
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  typedef enum logic {
    IDLE,
    COLLECT
  } frame_state_t;

  // True when exactly one active-low select line is asserted.
  function automatic logic single_low(input logic [NUM_DIGITS-1:0] sel_n);
    logic [NUM_DIGITS-1:0] act;
    act = ~sel_n;
    return (act != '0) && ((act & (act - NUM_DIGITS'(1))) == '0);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational active-high gfedcba pattern to BCD decoder
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       valid
);

  always_comb begin
    bcd   = BCD_INVALID;
    valid = 1'b1;
    case (seg)
      SEG_0:   bcd = 4'd0;
      SEG_1:   bcd = 4'd1;
      SEG_2:   bcd = 4'd2;
      SEG_3:   bcd = 4'd3;
      SEG_4:   bcd = 4'd4;
      SEG_5:   bcd = 4'd5;
      SEG_6:   bcd = 4'd6;
      SEG_7:   bcd = 4'd7;
      SEG_8:   bcd = 4'd8;
      SEG_9:   bcd = 4'd9;
      default: begin
        bcd   = BCD_INVALID;
        valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seg7_scan_rx.sv
// rtl/seg7_scan_rx.sv - four-digit seven-segment scan receiver; SEG7_DP_EN adds decimal points
module seg7_scan_rx
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_DIGITS-1:0] dig_sel_n,
`ifdef SEG7_DP_EN
  input  logic [7:0]            seg_n,
  output logic [NUM_DIGITS-1:0] dp,
`else
  input  logic [6:0]            seg_n,
`endif
  output logic [3:0]            digit0,
  output logic [3:0]            digit1,
  output logic [3:0]            digit2,
  output logic [3:0]            digit3,
  output logic                  frame_done,
  output logic                  seg_err
);

`ifdef SEG7_DP_EN
  localparam int SEG_W = 8;
`else
  localparam int SEG_W = 7;
`endif
  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

  logic [NUM_DIGITS-1:0] sel_s1, sel_s2, sel_prev;
  logic [SEG_W-1:0]      seg_s1, seg_s2, seg_prev;
  logic [7:0]            stable_cnt;
  logic                  armed;

  logic                  active_now;
  logic                  active_prev;
  logic                  same;
  logic                  capture;
  logic [1:0]            cap_idx;
  logic [6:0]            seg_act;
  logic [3:0]            dec_bcd;
  logic                  dec_valid;

  frame_state_t                state;
  logic [NUM_DIGITS-1:0]       seen_mask;
  logic [NUM_DIGITS-1:0][3:0]  work;
`ifdef SEG7_DP_EN
  logic [NUM_DIGITS-1:0]       dp_work;
`endif

  // Reset to the blank pattern so nothing looks like an active window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_s1   <= '1;
      sel_s2   <= '1;
      sel_prev <= '1;
      seg_s1   <= '1;
      seg_s2   <= '1;
      seg_prev <= '1;
    end else begin
      sel_s1   <= dig_sel_n;
      sel_s2   <= sel_s1;
      sel_prev <= sel_s2;
      seg_s1   <= seg_n;
      seg_s2   <= seg_s1;
      seg_prev <= seg_s2;
    end
  end

  assign active_now  = single_low(sel_s2);
  assign active_prev = single_low(sel_prev);
  assign same        = (sel_s2 == sel_prev) && (seg_s2 == seg_prev);
  // A saturated count means the pattern now in the *_prev stage was held long enough.
  assign capture     = armed && active_prev && (stable_cnt == CNT_MAX);
  assign seg_act     = ~seg_prev[6:0];

  always_comb begin
    cap_idx = 2'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!sel_prev[i]) cap_idx = 2'(i);
    end
  end

  seg7_decode u_decode (
    .seg   (seg_act),
    .bcd   (dec_bcd),
    .valid (dec_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_cnt <= '0;
      armed      <= 1'b1;
    end else begin
      if (!active_now || !same) begin
        stable_cnt <= '0;
      end else if (stable_cnt != CNT_MAX) begin
        stable_cnt <= stable_cnt + 8'd1;
      end
      // Re-arm wins so a window ending on its capture edge does not block the next one.
      if (!active_now || (sel_s2 != sel_prev)) begin
        armed <= 1'b1;
      end else if (capture) begin
        armed <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      seen_mask  <= '0;
      work       <= '0;
      digit0     <= 4'h0;
      digit1     <= 4'h0;
      digit2     <= 4'h0;
      digit3     <= 4'h0;
      frame_done <= 1'b0;
      seg_err    <= 1'b0;
`ifdef SEG7_DP_EN
      dp_work    <= '0;
      dp         <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      if (capture) begin
        work[cap_idx]      <= dec_bcd;
        seen_mask[cap_idx] <= 1'b1;
        if (!dec_valid) seg_err <= 1'b1;
`ifdef SEG7_DP_EN
        dp_work[cap_idx]   <= ~seg_prev[7];
`endif
      end
      case (state)
        IDLE: begin
          if (capture) state <= COLLECT;
        end
        COLLECT: begin
          if (seen_mask == '1) begin
            digit0     <= work[0];
            digit1     <= work[1];
            digit2     <= work[2];
            digit3     <= work[3];
`ifdef SEG7_DP_EN
            dp         <= dp_work;
`endif
            frame_done <= 1'b1;
            seen_mask  <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan_rx.sv
// tb/tb_seg7_scan_rx.sv - self-checking bench for seg7_scan_rx against a window-level model
module tb_seg7_scan_rx;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] dig_sel_n;
`ifdef SEG7_DP_EN
  logic [7:0] seg_n;
  logic [3:0] dp;
`else
  logic [6:0] seg_n;
`endif
  logic [3:0] digit0, digit1, digit2, digit3;
  logic       frame_done, seg_err;

  seg7_scan_rx #(.STABLE_CYCLES(S)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dig_sel_n  (dig_sel_n),
    .seg_n      (seg_n),
`ifdef SEG7_DP_EN
    .dp         (dp),
`endif
    .digit0     (digit0),
    .digit1     (digit1),
    .digit2     (digit2),
    .digit3     (digit3),
    .frame_done (frame_done),
    .seg_err    (seg_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_miss = 0;
  int n_exp  = 0;
  int n_got  = 0;

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic        err;
    int          cyc;
  } frame_t;
  frame_t exp_q[$];

  logic [6:0] codes [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic [3:0] m_work [4];
  logic [3:0] m_seen;
  logic [3:0] m_dp;
  logic       m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] sel_of(input int d);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << d);
  endfunction

  function automatic logic [3:0] ref_decode(input logic [6:0] c);
    for (int i = 0; i < 10; i++) if (c == codes[i]) return 4'(i);
    return 4'hF;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_work[i] = 4'h0;
    m_seen = 4'h0;
    m_dp   = 4'h0;
    m_err  = 1'b0;
  endtask

  // A window is captured when exactly one select is low and it lasts at least S cycles.
  task automatic model_window(input logic [3:0] sel, input logic [6:0] code, input logic dpb,
                              input int len, input int start);
    frame_t f;
    int d;
    if ($countones(~sel) == 1 && len >= S) begin
      d = 0;
      for (int i = 0; i < 4; i++) if (!sel[i]) d = i;
      m_work[d] = ref_decode(code);
      m_dp[d]   = dpb;
      m_seen[d] = 1'b1;
      if (m_work[d] == 4'hF) m_err = 1'b1;
      if (m_seen == 4'hF) begin
        f.digits = {m_work[3], m_work[2], m_work[1], m_work[0]};
        f.dp     = m_dp;
        f.err    = m_err;
        f.cyc    = start + S + 4;
        exp_q.push_back(f);
        n_exp++;
        m_seen = 4'h0;
      end
    end
  endtask

  // Called just after a negedge; returns just after a negedge.
  task automatic window(input logic [3:0] sel, input logic [6:0] code, input logic dpb,
                        input int len, input int gap);
    model_window(sel, code, dpb, len, cyc);
    dig_sel_n = sel;
`ifdef SEG7_DP_EN
    seg_n = {~dpb, ~code};
`else
    seg_n = ~code;
`endif
    repeat (len) @(negedge clk);
    dig_sel_n = 4'hF;
    seg_n     = '1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic frame4(input logic [6:0] c0, input logic [6:0] c1,
                        input logic [6:0] c2, input logic [6:0] c3);
    window(sel_of(0), c0, 1'b0, 10, 2);
    window(sel_of(1), c1, 1'b0, 10, 2);
    window(sel_of(2), c2, 1'b0, 10, 2);
    window(sel_of(3), c3, 1'b0, 10, 2);
  endtask

  task automatic drain(input string tag);
    repeat (8) @(negedge clk);
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    frame_t f;
    if (rst_n === 1'b1 && frame_done === 1'b1) begin
      n_got++;
      check("frame_count", n_got, n_exp);
      if (exp_q.size() > 0) begin
        f = exp_q.pop_front();
        check("frame_digits", {digit3, digit2, digit1, digit0}, f.digits);
        check("frame_seg_err", seg_err, f.err);
        check("frame_cycle", cyc, f.cyc);
`ifdef SEG7_DP_EN
        check("frame_dp", dp, f.dp);
`endif
      end
    end
  end

  initial begin
    logic [3:0] sel, last_sel;
    logic [6:0] code;
    int len, gap, last_gap;

    rst_n     = 1'b0;
    dig_sel_n = 4'hF;
    seg_n     = '1;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_digits", {digit3, digit2, digit1, digit0}, 16'h0000);
    check("reset_frame_done", frame_done, 1'b0);
    check("reset_seg_err", seg_err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame 1,2,3,4
    frame4(7'h06, 7'h5B, 7'h4F, 7'h66);
    drain("basic_pending");
    check("basic_digits", {digit3, digit2, digit1, digit0}, 16'h4321);
    check("basic_seg_err", seg_err, 1'b0);

    // Short digit-2 window must be ignored until digit 2 is shown stably
    window(sel_of(0), 7'h3F, 1'b0, 10, 2);
    window(sel_of(1), 7'h06, 1'b0, 10, 2);
    window(sel_of(2), 7'h7F, 1'b0, 3, 2);
    window(sel_of(3), 7'h4F, 1'b0, 10, 2);
    check("glitch_no_frame", n_got, n_exp);
    window(sel_of(2), 7'h7F, 1'b0, 10, 2);
    drain("glitch_pending");
    check("glitch_digits", {digit3, digit2, digit1, digit0}, 16'h3810);

    // Blank code on digit 1, then a valid frame with sticky error
    frame4(7'h66, 7'h00, 7'h6D, 7'h7D);
    drain("invalid_pending");
    check("invalid_digit1", digit1, 4'hF);
    frame4(7'h07, 7'h7F, 7'h6F, 7'h3F);
    drain("sticky_pending");
    check("sticky_seg_err", seg_err, 1'b1);

    // Two selects low is a blank state
    dig_sel_n = 4'b0011;
    seg_n     = ~7'h06;
    repeat (10) @(negedge clk);
    check("multi_cnt_zero", dut.stable_cnt, 8'd0);
    repeat (10) @(negedge clk);
    check("multi_no_frame", n_got, n_exp);
    frame4(7'h6D, 7'h06, 7'h5B, 7'h4F);
    drain("multi_pending");

    // Repeat capture overwrites digit 0
    window(sel_of(0), 7'h6D, 1'b0, 10, 2);
    window(sel_of(0), 7'h07, 1'b0, 10, 2);
    window(sel_of(1), 7'h06, 1'b0, 10, 2);
    window(sel_of(2), 7'h06, 1'b0, 10, 2);
    window(sel_of(3), 7'h06, 1'b0, 10, 2);
    drain("repeat_pending");
    check("repeat_digit0", digit0, 4'h7);

    // Reset after two captures
    window(sel_of(0), 7'h7D, 1'b0, 10, 2);
    window(sel_of(1), 7'h7F, 1'b0, 10, 2);
    rst_n = 1'b0;
    #1;
    check("midrst_digits", {digit3, digit2, digit1, digit0}, 16'h0000);
    check("midrst_seg_err", seg_err, 1'b0);
    check("midrst_frame_done", frame_done, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    window(sel_of(2), 7'h5B, 1'b0, 10, 2);
    window(sel_of(3), 7'h4F, 1'b0, 10, 2);
    drain("midrst_partial");
    check("midrst_no_frame", {digit3, digit2, digit1, digit0}, 16'h0000);
    frame4(7'h6F, 7'h66, 7'h5B, 7'h06);
    drain("midrst_full");

`ifdef SEG7_DP_EN
    window(sel_of(0), 7'h06, 1'b0, 10, 2);
    window(sel_of(1), 7'h06, 1'b0, 10, 2);
    window(sel_of(2), 7'h06, 1'b0, 10, 2);
    window(sel_of(3), 7'h06, 1'b1, 10, 2);
    drain("dp_pending");
    check("dp_digit3_only", dp, 4'b1000);
`endif

    // Randomized scan traffic
    last_sel = 4'hF;
    last_gap = 1;
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 99) < 88) sel = sel_of(int'($urandom_range(0, 3)));
      else sel = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) < 9) code = codes[$urandom_range(0, 9)];
      else code = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 9) < 7) len = int'($urandom_range(S, S + 8));
      else len = int'($urandom_range(1, S - 1));
      gap = int'($urandom_range(0, 2));
      // Same select with no blank in between would merge into one window.
      if (last_gap == 0 && sel == last_sel) @(negedge clk);
      window(sel, code, 1'($urandom_range(0, 1)), len, gap);
      last_sel = sel;
      last_gap = gap;
    end
    drain("random_pending");
    check("random_frame_total", n_got, n_exp);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
